command_assembler: RTL and testbench

Upstream framing stage for `command_controller`. Collects a serial stream of received words (e.g. UART bytes) into one fixed-length command frame: command word, address word, value words, most-significant first. On a complete frame it presents the frame as a single wide word with a one-cycle data-valid pulse, matching `command_controller`'s `i_data`/`i_dv` inputs. Frames that start with an unknown command word are discarded, and stalled partial frames are abandoned after an inter-word timeout.

---
 rtl/cmd_pkg.sv | 16 +
 rtl/idle_timer.sv | 29 ++
 rtl/command_assembler.sv | 90 +++++++++
 tb/tb_command_assembler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Constants and state type shared by the command framing and command
// handling blocks, so both agree on the command codes.
package cmd_pkg;

    localparam logic [7:0] READ_CMD  = 8'h00;
    localparam logic [7:0] WRITE_CMD = 8'hAA;

    localparam int DEFAULT_WORD_WIDTH  = 8;
    localparam int DEFAULT_FRAME_WORDS = 6;

    typedef enum logic {
        IDLE,
        COLLECT
    } asm_state_t;

endpackage

// File: rtl/idle_timer.sv
// Saturating idle counter for serial front ends; 'expired' flags the enabled
// cycle whose edge brings the count up to LIMIT.
module idle_timer #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != CW'(LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && !clear && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/command_assembler.sv
// Gathers a serial word stream into fixed-length command frames, dropping
// frames with unknown command words and partial frames that stall too long.
module command_assembler
    import cmd_pkg::*;
#(
    parameter int WORD_WIDTH     = DEFAULT_WORD_WIDTH,
    parameter int FRAME_WORDS    = DEFAULT_FRAME_WORDS,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              i_reset_n,
    input  logic [WORD_WIDTH-1:0]             i_word,
    input  logic                              i_word_dv,
    output logic [WORD_WIDTH*FRAME_WORDS-1:0] o_data,
    output logic                              o_dv,
    output logic                              o_busy,
    output logic                              o_timeout
);

    // The final word goes straight to o_data, so only the earlier words are held.
    localparam int HOLD_W = WORD_WIDTH * (FRAME_WORDS - 1);
    localparam int CNT_W  = $clog2(FRAME_WORDS + 1);

    asm_state_t        state;
    logic [HOLD_W-1:0] held;
    logic [CNT_W-1:0]  word_count;
    logic              is_command;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_expired;

    assign is_command   = (i_word == WORD_WIDTH'(READ_CMD)) ||
                          (i_word == WORD_WIDTH'(WRITE_CMD));
    assign timer_clear  = (state == IDLE) || i_word_dv;
    assign timer_enable = (state == COLLECT) && !i_word_dv;
    assign o_busy       = (state == COLLECT);

    idle_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .reset_n (i_reset_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            held       <= '0;
            word_count <= '0;
            o_data     <= '0;
            o_dv       <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            o_dv      <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_word_dv && is_command) begin
                        held       <= HOLD_W'(i_word);
                        word_count <= CNT_W'(1);
                        state      <= COLLECT;
                    end
                end
                COLLECT: begin
                    // An arriving word always beats a timer expiring on the same edge.
                    if (i_word_dv) begin
                        if (word_count == CNT_W'(FRAME_WORDS - 1)) begin
                            o_data     <= {held, i_word};
                            o_dv       <= 1'b1;
                            word_count <= '0;
                            state      <= IDLE;
                        end else begin
                            held       <= (held << WORD_WIDTH) | HOLD_W'(i_word);
                            word_count <= word_count + CNT_W'(1);
                        end
                    end else if (timer_expired) begin
                        o_timeout  <= 1'b1;
                        word_count <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_command_assembler.sv
// Directed bench for command_assembler with a short timeout; frames, resync,
// timeout boundaries, back-to-back frames and mid-frame reset.
module tb_command_assembler;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [7:0]  i_word;
    logic        i_word_dv;
    logic [47:0] o_data;
    logic        o_dv;
    logic        o_busy;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    int          dv_count = 0;
    int          to_count = 0;
    int          both_count = 0;
    logic [47:0] dv_log [16];

    int dv_base;
    int to_base;

    command_assembler #(
        .WORD_WIDTH     (8),
        .FRAME_WORDS    (6),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_word    (i_word),
        .i_word_dv (i_word_dv),
        .o_data    (o_data),
        .o_dv      (o_dv),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    // Pulses are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (o_dv) begin
            if (dv_count < 16) dv_log[dv_count] = o_data;
            dv_count = dv_count + 1;
        end
        if (o_timeout) to_count = to_count + 1;
        if (o_dv && o_timeout) both_count = both_count + 1;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int idle);
        i_word    = w;
        i_word_dv = 1'b1;
        tick(1);
        i_word_dv = 1'b0;
        tick(idle);
    endtask

    task automatic send_frame(input logic [47:0] f, input int idle);
        for (int i = 5; i >= 0; i--) send_word(f[i*8 +: 8], idle);
    endtask

    task automatic mark;
        dv_base = dv_count;
        to_base = to_count;
    endtask

    initial begin
        i_reset_n = 1'b1;
        i_word    = 8'h00;
        i_word_dv = 1'b0;
        #2 i_reset_n = 1'b0;
        #1;
        check_output("reset_data", 64'(o_data), 64'h0);
        check_output("reset_dv", 64'(o_dv), 64'h0);
        check_output("reset_busy", 64'(o_busy), 64'h0);
        check_output("reset_timeout", 64'(o_timeout), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1 i_reset_n = 1'b1;
        tick(2);

        // Read frame, one word per 10 cycles
        mark();
        send_frame(48'h001212345678, 9);
        tick(2);
        check_output("read_dv_count", 64'(dv_count - dv_base), 64'd1);
        check_output("read_data", 64'(dv_log[dv_base]), 64'h001212345678);
        check_output("read_busy_after", 64'(o_busy), 64'h0);

        // Write frame
        mark();
        send_frame(48'hAA2187654321, 2);
        tick(2);
        check_output("write_dv_count", 64'(dv_count - dv_base), 64'd1);
        check_output("write_data", 64'(dv_log[dv_base]), 64'hAA2187654321);

        // Resync past unknown command words
        mark();
        send_word(8'h55, 2);
        send_word(8'h3C, 2);
        check_output("resync_busy", 64'(o_busy), 64'h0);
        check_output("resync_no_pulse", 64'(dv_count - dv_base + to_count - to_base), 64'd0);
        send_frame(48'hAA2187654321, 2);
        tick(2);
        check_output("resync_dv_count", 64'(dv_count - dv_base), 64'd1);
        check_output("resync_data", 64'(dv_log[dv_base]), 64'hAA2187654321);

        // Timeout after exactly 20 idle cycles
        mark();
        send_word(8'hAA, 2);
        send_word(8'h21, 2);
        check_output("timeout_busy_mid", 64'(o_busy), 64'h1);
        send_word(8'h87, 20);
        tick(3);
        check_output("timeout_count", 64'(to_count - to_base), 64'd1);
        check_output("timeout_no_dv", 64'(dv_count - dv_base), 64'd0);
        check_output("timeout_busy_after", 64'(o_busy), 64'h0);
        mark();
        send_frame(48'h00ABCDEF0123, 2);
        tick(2);
        check_output("after_timeout_dv", 64'(dv_count - dv_base), 64'd1);
        check_output("after_timeout_data", 64'(dv_log[dv_base]), 64'h00ABCDEF0123);

        // 19 idle cycles: the next word arrives on the expiry edge and wins
        mark();
        send_word(8'hAA, 2);
        send_word(8'h21, 2);
        send_word(8'h87, 19);
        send_word(8'h65, 2);
        send_word(8'h43, 2);
        send_word(8'h21, 2);
        tick(2);
        check_output("gap19_no_timeout", 64'(to_count - to_base), 64'd0);
        check_output("gap19_dv", 64'(dv_count - dv_base), 64'd1);
        check_output("gap19_data", 64'(dv_log[dv_base]), 64'hAA2187654321);

        // Back-to-back frames with continuous strobe
        mark();
        send_frame(48'hAA0102030405, 0);
        send_frame(48'h00F0E0D0C0B0, 0);
        tick(2);
        check_output("b2b_dv_count", 64'(dv_count - dv_base), 64'd2);
        check_output("b2b_data0", 64'(dv_log[dv_base]), 64'hAA0102030405);
        check_output("b2b_data1", 64'(dv_log[dv_base + 1]), 64'h00F0E0D0C0B0);

        // Reset in the middle of a frame
        mark();
        send_word(8'h00, 2);
        send_word(8'h12, 2);
        send_word(8'h12, 2);
        check_output("midreset_busy_before", 64'(o_busy), 64'h1);
        i_reset_n = 1'b0;
        #1;
        check_output("midreset_data", 64'(o_data), 64'h0);
        check_output("midreset_busy", 64'(o_busy), 64'h0);
        check_output("midreset_dv", 64'(o_dv), 64'h0);
        check_output("midreset_timeout", 64'(o_timeout), 64'h0);
        tick(2);
        i_reset_n = 1'b1;
        tick(25);
        check_output("midreset_no_pulse", 64'(dv_count - dv_base + to_count - to_base), 64'd0);
        send_frame(48'h0055AA0011FF, 2);
        tick(2);
        check_output("postreset_dv", 64'(dv_count - dv_base), 64'd1);
        check_output("postreset_data", 64'(dv_log[dv_base]), 64'h0055AA0011FF);

        check_output("dv_timeout_exclusive", 64'(both_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
